// File: rtl/demux_pkg.sv
// Shared types for the 1-to-3 packet-locked stream demultiplexer.
// Holds the FSM state encoding, the route type and the select decode.
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [1:0] route_t;

  localparam route_t OUT0 = 2'd0;
  localparam route_t OUT1 = 2'd1;
  localparam route_t OUT2 = 2'd2;

  // s1 wins: any select with bit 1 set goes to output 2.
  function automatic route_t sel_decode(input logic [1:0] sel);
    if (sel[1]) begin
      return OUT2;
    end else if (sel[0]) begin
      return OUT1;
    end else begin
      return OUT0;
    end
  endfunction

endpackage

// File: rtl/out_slot.sv
// One-entry output register slice with a delivered-beat counter.
// can_load is high when the slot is empty or is handing off its beat this cycle.
module out_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] cnt,
  output logic             can_load
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain  = r_valid && ready;
  assign can_load = !r_valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // A load on the same edge as a drain replaces the beat and keeps valid.
      if (load) begin
        r_data  <= load_data;
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (w_drain) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign cnt   = r_cnt;

endmodule

// File: rtl/demux1x3_router.sv
// Registered 1-to-3 stream demultiplexer: the first beat's select picks the
// output and that route is locked until the packet's last beat is accepted.
module demux1x3_router
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output state_t           o_dbg_state
);

  // Handshake: a beat moves on any edge where valid && ready; ready never
  // depends on the same interface's valid, so there is no combinational loop.

  state_t r_state, w_next_state;
  route_t r_lock, w_lock_next;
  route_t w_target;
  logic   w_tgt_can, w_accept;
  logic   w_can0, w_can1, w_can2;
  logic   w_load0, w_load1, w_load2;

  assign w_target = (r_state == IDLE) ? sel_decode(in_sel) : r_lock;

  always_comb begin
    w_tgt_can = 1'b0;
    case (w_target)
      OUT0:    w_tgt_can = w_can0;
      OUT1:    w_tgt_can = w_can1;
      OUT2:    w_tgt_can = w_can2;
      default: w_tgt_can = 1'b0;
    endcase
  end

  assign in_ready = !rst && w_tgt_can;
  assign w_accept = in_valid && in_ready;
  assign w_load0  = w_accept && (w_target == OUT0);
  assign w_load1  = w_accept && (w_target == OUT1);
  assign w_load2  = w_accept && (w_target == OUT2);

  always_comb begin
    w_next_state = r_state;
    w_lock_next  = r_lock;
    case (r_state)
      IDLE: begin
        if (w_accept && !in_last) begin
          w_next_state = BUSY;
          w_lock_next  = w_target;
        end
      end
      BUSY: begin
        if (w_accept && in_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_lock  <= OUT0;
    end else begin
      r_state <= w_next_state;
      r_lock  <= w_lock_next;
    end
  end

  assign o_dbg_state = r_state;

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk(clk), .rst(rst), .load(w_load0), .load_data(in_data),
    .data(out0_data), .valid(out0_valid), .ready(out0_ready),
    .cnt(cnt0), .can_load(w_can0)
  );

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk(clk), .rst(rst), .load(w_load1), .load_data(in_data),
    .data(out1_data), .valid(out1_valid), .ready(out1_ready),
    .cnt(cnt1), .can_load(w_can1)
  );

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot2 (
    .clk(clk), .rst(rst), .load(w_load2), .load_data(in_data),
    .data(out2_data), .valid(out2_valid), .ready(out2_ready),
    .cnt(cnt2), .can_load(w_can2)
  );

endmodule

// File: doc/demux1x3_router.md
# demux1x3_router

Registered 1-to-3 stream demultiplexer with packet-lock routing: the inverse of the 3:1 select path. One input valid/ready stream, with data, a 2-bit select and a last flag, is steered to one of three output streams, each with a one-entry output register. The select is sampled on the first beat of a packet and held until its last beat. The block sits between a single producer and three independent consumers, and keeps a per-output delivered-beat counter for debug.

## Interface
- WIDTH, 8, data width in bits
- CNT_W, 8, width of each delivered-beat counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  input beat payload
- in_sel  input  2  route select: bit 1 = s1, bit 0 = s0
- in_last  input  1  marks the final beat of a packet
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept the input beat
- out0_data, out1_data, out2_data  output  WIDTH  per-output payload
- out0_valid, out1_valid, out2_valid  output  1  per-output beat valid
- out0_ready, out1_ready, out2_ready  input  1  per-output consumer ready
- cnt0, cnt1, cnt2  output  CNT_W  beats delivered on each output (valid && ready)

## Operation
- Select decode, s1 has priority:
  - in_sel[1]=1 → output 2, regardless of bit 0
  - 01 → output 1
  - 00 → output 0
- FSM states are IDLE and BUSY.
  - IDLE: the target is decode(in_sel).
    - Accepted beat with in_last=0 → BUSY; the target is latched into lock.
    - Accepted beat with in_last=1 → stay in IDLE (single-beat packet).
  - BUSY: the target is lock; in_sel is ignored.
    - Accepted beat with in_last=1 → IDLE.
  - Without an accepted beat, the state holds.
- Input accept: in_valid && in_ready.
  - in_ready = !rst && (target slot empty || target slot draining this cycle).
  - in_ready is combinational from slot state, out*_ready and (in IDLE) in_sel.
- Output slot N:
  - Loads in_data and sets outN_valid on an accept targeting N.
  - Clears outN_valid on an outN handshake with no simultaneous load.
  - On simultaneous drain and load, it holds the new beat with valid=1.
  - While outN_valid && !outN_ready, outN_data is stable.
- Non-target slots are unaffected by input traffic and drain independently.
- Counters: cntN increments by 1 on each outN_valid && outN_ready. It wraps from 2^CNT_W−1 to 0 with no saturation or flag.
- in_last is not forwarded; packet framing is local to the router.

## Timing
- Reset (async assert, sync release at the clk edge), all at 0:
  - state IDLE, lock 0
  - all outN_valid, outN_data and cntN
  - in_ready 0 while rst is high, 1 in the first cycle after release
- Latency: a beat accepted at edge k appears on outN_valid/outN_data after edge k.
  - Sustained throughput is 1 beat/cycle to one output when the consumer keeps ready high.
- Back-pressure: if the target slot is full and its ready is low, in_ready=0. Input stalls and no beat is dropped or reordered.
- Mid-packet select change: in_sel toggling in BUSY has no effect; all beats up to and including in_last go to lock.
- Packet boundary: the beat after in_last is routed by the new in_sel in the same cycle it is presented.
- Reset mid-packet:
  - Slot contents are discarded and the counters cleared.
  - FSM returns to IDLE, so the next beat is treated as a packet start.

## Structure
- Package demux_pkg:
  - state enum (IDLE, BUSY)
  - 2-bit route type with constants OUT0=0, OUT1=1, OUT2=2
  - function sel_decode(in_sel) implementing the s1-priority decode
- Sub-module out_slot (WIDTH, CNT_W): one-entry register slice plus beat counter.
  - Ports: clk, rst, load, load_data, data, valid, ready, cnt, can_load.
  - Instantiated three times.
- Top level holds the FSM, lock register, target mux and in_ready.

## Test plan
- Single-beat routing: in_data=0xA5 with in_sel 00, 01, 10, 11, each with in_last=1 and all readies high.
  - 0xA5 appears one cycle later on out0, out1, out2, out2 respectively.
  - Final counts: cnt0=1, cnt1=1, cnt2=2.
- Packet lock: in_sel=01 on the first beat, then in_sel=10 on beats 2–4 (last on beat 4), data 0x10..0x13.
  - All four beats arrive on out1 in order; out2_valid stays 0.
  - A following beat with in_sel=10 goes to out2.
- Back-pressure: out0_ready=0, send two beats to out0.
  - First beat is held with stable data; in_ready=0 for the second.
  - Raise out0_ready: both beats are delivered in order and cnt0=2.
- Independent drain: out0 stalled with one beat held, then new packet to out1.
  - The out1 packet is accepted and delivered while out0 holds 0xA5 unchanged.
- Counter wrap with CNT_W=4: deliver 17 beats to out2 → cnt2=1.
- Reset mid-packet: assert rst after beat 2 of a 4-beat packet to out1.
  - All valids and counts read 0 and the FSM is in IDLE.
  - The next beat with in_sel=00 goes to out0.
